// File: rtl/diabetes_detector.sv
// -----------------------------------------------------------------------------
// diabetes_detector
//
// Board-level diabetes classifier for the DE10-Lite. The operator keys in
// eight patient attributes as decimal numbers, using the slide switches as
// digit keys and KEY[1] as "next". After the eighth attribute a fixed
// decision rule is applied. The verdict is shown on the seven-segment
// displays and on the LEDs.
//
// Ports
//   ADC_CLK_10      in   system clock; all state changes on its rising edge
//   KEY[0]          in   synchronous active-high reset/clear
//   KEY[1]          in   "next": a rising edge commits the current field
//   SW[0:9]         in   digit keys: a rising edge on SW[n] enters digit n
//   HEX5..HEX0[0:6] out  seven-segment displays, active-low,
//                        bit 0 = segment a ... bit 6 = segment g
//   LEDR[0:9]       out  status LEDs, active-high
//
// Field order: 0 pregnancies, 1 glucose, 2 blood pressure, 3 skin thickness,
// 4 insulin, 5 BMI, 6 pedigree x1000, 7 age.
//
// Input event semantics: SW and KEY[1] are asynchronous levels. Each passes
// through s1 (synchronizer) and s2 (history). The one-cycle event pulse is
// s1 & ~s2, and registered state consumes that pulse on the next rising edge.
// A level that stays high produces exactly one event. While reset is held,
// s1 and s2 both load the live level, so an input held across reset release
// produces no event.
// -----------------------------------------------------------------------------
module diabetes_detector (
    input  logic        ADC_CLK_10,
    input  logic [0:1]  KEY,
    input  logic [0:9]  SW,
    output logic [0:6]  HEX5,
    output logic [0:6]  HEX4,
    output logic [0:6]  HEX3,
    output logic [0:6]  HEX2,
    output logic [0:6]  HEX1,
    output logic [0:6]  HEX0,
    output logic [0:9]  LEDR
);

    // -------------------------------------------------------------------------
    // Glyphs (active-low, bits [0:6] = segments a..g)
    // -------------------------------------------------------------------------
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_P     = 7'b0011000;
    localparam logic [0:6] SEG_O     = 7'b0000001;
    localparam logic [0:6] SEG_S     = 7'b0100100;
    localparam logic [0:6] SEG_N     = 7'b1101010;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_G     = 7'b0100001;

    function automatic logic [0:6] seg_digit(input logic [3:0] d);
        logic [0:6] g;
        case (d)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // -------------------------------------------------------------------------
    // State encoding: ST_E0..ST_E7 are ENTRY(k); the low three bits are k.
    // -------------------------------------------------------------------------
    typedef enum logic [3:0] {
        ST_E0     = 4'd0,
        ST_E1     = 4'd1,
        ST_E2     = 4'd2,
        ST_E3     = 4'd3,
        ST_E4     = 4'd4,
        ST_E5     = 4'd5,
        ST_E6     = 4'd6,
        ST_E7     = 4'd7,
        ST_RESULT = 4'd8
    } state_t;

    logic        clk;
    logic        rst;

    assign clk = ADC_CLK_10;
    assign rst = KEY[0];

    state_t      state;
    state_t      next_state;
    logic        in_entry;
    logic [2:0]  entry_idx;

    // Input synchronizers and edge detection
    logic [0:9]  sw_s1;
    logic [0:9]  sw_s2;
    logic [0:9]  sw_edge;
    logic        nxt_s1;
    logic        nxt_s2;
    logic        nxt_edge;

    // Digit selection
    logic        digit_hit;
    logic [3:0]  digit_val;

    // Entry datapath
    logic [13:0] acc;
    logic [13:0] acc_next;
    logic [15:0] acc_bcd;     // the same value as acc, kept as 4 BCD digits
    logic [2:0]  digit_cnt;
    logic [13:0] field [0:7];
    logic        verdict;
    logic        verdict_next;

    assign in_entry  = (state != ST_RESULT);
    assign entry_idx = state[2:0];

    // -------------------------------------------------------------------------
    // Synchronizers. Reset loads the live level into both stages so that a
    // switch already up at release is not mistaken for a fresh press.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1  <= SW;
            sw_s2  <= SW;
            nxt_s1 <= KEY[1];
            nxt_s2 <= KEY[1];
        end else begin
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
            nxt_s1 <= KEY[1];
            nxt_s2 <= nxt_s1;
        end
    end

    assign sw_edge  = sw_s1 & ~sw_s2;
    assign nxt_edge = nxt_s1 & ~nxt_s2;

    // Lowest switch index wins when several rise together: scanning
    // downward lets the lowest set index overwrite the others.
    always_comb begin
        digit_hit = 1'b0;
        digit_val = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (sw_edge[i]) begin
                digit_hit = 1'b1;
                digit_val = 4'(i);
            end
        end
    end

    // At most three digits precede the one being added, so acc <= 999 here
    // and acc*10 + 9 <= 9999 always fits in 14 bits.
    assign acc_next = (acc * 14'd10) + {10'd0, digit_val};

    // -------------------------------------------------------------------------
    // Decision rule. On the final "next" the age is still in acc, so it is
    // taken from there rather than from field[7].
    // -------------------------------------------------------------------------
    always_comb begin
        verdict_next = 1'b0;
        if (field[1] >= 14'd128) begin
            verdict_next = (field[5] >= 14'd30) || (field[1] >= 14'd158);
        end else begin
            verdict_next = (field[5] >= 14'd27) && (acc >= 14'd29) &&
                           (field[6] >= 14'd500);
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_E0;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. RESULT is left only through reset.
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        if (in_entry && nxt_edge) begin
            if (state == ST_E7) begin
                next_state = ST_RESULT;
            end else begin
                next_state = state_t'(state + 4'd1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Entry datapath. "next" takes priority over a digit in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= 14'd0;
            acc_bcd   <= 16'd0;
            digit_cnt <= 3'd0;
            verdict   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                field[i] <= 14'd0;
            end
        end else if (in_entry) begin
            if (nxt_edge) begin
                field[entry_idx] <= acc;
                acc              <= 14'd0;
                acc_bcd          <= 16'd0;
                digit_cnt        <= 3'd0;
                if (state == ST_E7) begin
                    verdict <= verdict_next;
                end
            end else if (digit_hit && (digit_cnt < 3'd4)) begin
                acc       <= acc_next;
                acc_bcd   <= {acc_bcd[11:0], digit_val};
                digit_cnt <= digit_cnt + 3'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output decode (purely from registered state)
    // -------------------------------------------------------------------------
    always_comb begin
        HEX5 = SEG_BLANK;
        HEX4 = SEG_BLANK;
        HEX3 = SEG_BLANK;
        HEX2 = SEG_BLANK;
        HEX1 = SEG_BLANK;
        HEX0 = SEG_BLANK;
        LEDR = '0;
        if (in_entry) begin
            HEX5 = seg_digit({1'b0, entry_idx} + 4'd1);
            HEX3 = seg_digit(acc_bcd[15:12]);
            HEX2 = seg_digit(acc_bcd[11:8]);
            HEX1 = seg_digit(acc_bcd[7:4]);
            HEX0 = seg_digit(acc_bcd[3:0]);
            LEDR[{1'b0, entry_idx}] = 1'b1;
        end else begin
            HEX2    = verdict ? SEG_P : SEG_N;
            HEX1    = verdict ? SEG_O : SEG_E;
            HEX0    = verdict ? SEG_S : SEG_G;
            LEDR[8] = 1'b1;
            LEDR[9] = verdict;
        end
    end

endmodule

// File: tb/tb_diabetes_detector.sv
module tb_diabetes_detector;

    logic       clk;
    logic [0:1] key;
    logic [0:9] sw;
    logic [0:6] hex5, hex4, hex3, hex2, hex1, hex0;
    logic [0:9] ledr;

    int n_checks = 0;
    int n_errors = 0;

    // Expected display snapshot: {HEX5..HEX0, LEDR}
    logic [51:0] exp_q[$];
    string       name_q[$];

    localparam logic [0:6] T_BLANK = 7'b1111111;
    localparam logic [0:6] T_P     = 7'b0011000;
    localparam logic [0:6] T_O     = 7'b0000001;
    localparam logic [0:6] T_S     = 7'b0100100;
    localparam logic [0:6] T_N     = 7'b1101010;
    localparam logic [0:6] T_E     = 7'b0110000;
    localparam logic [0:6] T_G     = 7'b0100001;

    diabetes_detector dut (
        .ADC_CLK_10 (clk),
        .KEY        (key),
        .SW         (sw),
        .HEX5       (hex5),
        .HEX4       (hex4),
        .HEX3       (hex3),
        .HEX2       (hex2),
        .HEX1       (hex1),
        .HEX0       (hex0),
        .LEDR       (ledr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic do_reset(input int cycles);
        @(negedge clk);
        key[0] = 1'b1;
        repeat (cycles) @(negedge clk);
        key[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- expected-value helpers ----------------
    function automatic logic [0:6] glyph(input int d);
        logic [0:6] g;
        case (d)
            0: g = 7'b0000001;
            1: g = 7'b1001111;
            2: g = 7'b0010010;
            3: g = 7'b0000110;
            4: g = 7'b1001100;
            5: g = 7'b0100100;
            6: g = 7'b0100000;
            7: g = 7'b0001111;
            8: g = 7'b0000000;
            9: g = 7'b0000100;
            default: g = T_BLANK;
        endcase
        return g;
    endfunction

    function automatic logic [51:0] exp_entry(input int k, input int v);
        logic [0:9] l;
        l = 10'b1000000000 >> k;
        return {glyph(k + 1), T_BLANK, glyph((v / 1000) % 10), glyph((v / 100) % 10),
                glyph((v / 10) % 10), glyph(v % 10), l};
    endfunction

    function automatic logic [51:0] exp_result(input bit pos);
        logic [0:9] l;
        l = pos ? 10'b0000000011 : 10'b0000000010;
        return {T_BLANK, T_BLANK, T_BLANK, pos ? T_P : T_N, pos ? T_O : T_E,
                pos ? T_S : T_G, l};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic press_digit(input int n);
        @(negedge clk);
        sw[n] = 1'b1;
        repeat (2) @(negedge clk);
        sw[n] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_next();
        @(negedge clk);
        key[1] = 1'b1;
        repeat (2) @(negedge clk);
        key[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic enter_value(input int v);
        int d[4];
        int n;
        n = 0;
        while (v > 0 && n < 4) begin
            d[n] = v % 10;
            v = v / 10;
            n++;
        end
        for (int i = n - 1; i >= 0; i--) press_digit(d[i]);
    endtask

    // Push an expectation; the monitor compares it on a later falling edge
    // while the inputs are held still.
    task automatic expect_disp(input logic [51:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        repeat (2) @(negedge clk);
    endtask

    task automatic enter_all(input int v[8], input bit pos, input string nm);
        for (int k = 0; k < 8; k++) begin
            enter_value(v[k]);
            expect_disp(exp_entry(k, v[k]), $sformatf("%s_field%0d", nm, k));
            press_next();
        end
        expect_disp(exp_result(pos), $sformatf("%s_result", nm));
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [51:0] act;
        logic [51:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {hex5, hex4, hex3, hex2, hex1, hex0, ledr};
                n_checks++;
                if (act !== e) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int pos_seq[8]  = '{6, 148, 72, 35, 0, 37, 627, 50};
        int neg_seq[8]  = '{1, 85, 66, 29, 0, 26, 351, 31};
        int g158[8]     = '{0, 158, 0, 0, 0, 20, 0, 0};
        int g127_pos[8] = '{2, 127, 60, 20, 0, 27, 500, 29};
        int g127_neg[8] = '{2, 127, 60, 20, 0, 27, 499, 29};
        int g128_neg[8] = '{3, 128, 70, 20, 0, 29, 900, 50};
        int g128_pos[8] = '{3, 128, 70, 20, 0, 30, 0, 20};
        int drain;

        key = 2'b00;
        sw  = '0;
        key[0] = 1'b1;
        repeat (3) @(negedge clk);
        key[0] = 1'b0;
        repeat (2) @(negedge clk);
        expect_disp(exp_entry(0, 0), "reset_state");

        // Field 0 left empty, then 148 typed into field 1
        press_next();
        expect_disp(exp_entry(1, 0), "entry1_empty");
        press_digit(1);
        press_digit(4);
        press_digit(8);
        expect_disp(exp_entry(1, 148), "entry1_0148");
        press_next();
        expect_disp(exp_entry(2, 0), "entry2_cleared");

        do_reset(2);
        enter_all(pos_seq, 1'b1, "pos_seq");

        do_reset(2);
        enter_all(neg_seq, 1'b0, "neg_seq");
        for (int i = 0; i < 5; i++) press_digit(i + 2);
        press_next();
        expect_disp(exp_result(1'b0), "result_ignores_input");

        // Fifth digit dropped; simultaneous edges resolve to lowest index
        do_reset(2);
        enter_value(1234);
        press_digit(5);
        expect_disp(exp_entry(0, 1234), "fifth_digit_ignored");
        press_next();
        @(negedge clk);
        sw[3] = 1'b1;
        sw[7] = 1'b1;
        repeat (2) @(negedge clk);
        sw = '0;
        repeat (2) @(negedge clk);
        expect_disp(exp_entry(1, 3), "lowest_index_wins");

        // Digit coinciding with next is ignored
        @(negedge clk);
        sw[9]  = 1'b1;
        key[1] = 1'b1;
        repeat (2) @(negedge clk);
        sw     = '0;
        key[1] = 1'b0;
        repeat (2) @(negedge clk);
        expect_disp(exp_entry(2, 0), "digit_with_next_ignored");

        // Reset pulse mid-entry
        do_reset(2);
        for (int i = 0; i < 4; i++) press_next();
        enter_value(12);
        expect_disp(exp_entry(4, 12), "entry4_acc12");
        do_reset(1);
        expect_disp(exp_entry(0, 0), "reset_mid_entry");
        enter_all(neg_seq, 1'b0, "neg_after_reset");

        // Switch held through reset release yields no digit
        @(negedge clk);
        sw[5]  = 1'b1;
        key[0] = 1'b1;
        repeat (2) @(negedge clk);
        key[0] = 1'b0;
        repeat (3) @(negedge clk);
        expect_disp(exp_entry(0, 0), "held_through_reset");
        sw = '0;
        repeat (2) @(negedge clk);

        // Decision-rule boundaries
        do_reset(2);
        enter_all(g158, 1'b1, "g158_b20");
        do_reset(2);
        enter_all(g127_pos, 1'b1, "g127_edge_pos");
        do_reset(2);
        enter_all(g127_neg, 1'b0, "g127_p499");
        do_reset(2);
        enter_all(g128_neg, 1'b0, "g128_b29");
        do_reset(2);
        enter_all(g128_pos, 1'b1, "g128_b30");

        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/diabetes_detector.md
# diabetes_detector

Standalone board-level classifier for the DE10-Lite. The operator keys in eight patient attributes as decimal numbers using the slide switches as digit keys. The block stores each attribute, shows the entry on the seven-segment displays, and applies a fixed decision rule after the eighth attribute. The verdict (diabetic / not diabetic) is shown on HEX and LEDR. Sits directly on the board pins; no other blocks.

## Interface
- No parameters.
- ADC_CLK_10 input 1: single system clock; all state updates on its rising edge.
- KEY[0] input 1: reset/clear, synchronous, active-high (KEY is declared [0:1]).
- KEY[1] input 1: "next" (proximo), active-high; a rising edge commits the current field.
- SW input [0:9]: digit keys; a rising edge on SW[n] enters digit n.
- HEX5, HEX4, HEX3, HEX2, HEX1, HEX0 output [0:6] each: seven-segment displays, active-low, bit 0 = segment a … bit 6 = segment g.
- LEDR output [0:9]: status LEDs, active-high.

## Operation
- Fields, in order: k=0 pregnancies, 1 glucose, 2 blood pressure, 3 skin thickness, 4 insulin, 5 BMI (integer), 6 pedigree ×1000, 7 age. Each field is an unsigned 14-bit register.
- States: ENTRY(k), k = 0..7, then RESULT. Reset gives ENTRY(0) with all fields, accumulator, digit count and verdict at 0.
- Digit entry (ENTRY only), in the order applied:
  - If digit count < 4: acc ← acc×10 + n and count ← count+1.
  - If count = 4: the digit is ignored.
  - If several SW bits rise in the same cycle, the lowest index wins.
- Next (ENTRY(k)):
  - field[k] ← acc; acc ← 0; count ← 0.
  - For k < 7, go to ENTRY(k+1).
  - For k = 7, go to RESULT and register the verdict computed with age = acc.
  - A digit edge in the same cycle as a next edge is ignored.
- Verdict (G glucose, B BMI, P pedigree, A age):
  - If G ≥ 128: positive iff B ≥ 30 or G ≥ 158.
  - Else: positive iff B ≥ 27 and A ≥ 29 and P ≥ 500.
- RESULT:
  - Digits and next are ignored.
  - Only reset leaves RESULT.
- Displays in ENTRY(k):
  - HEX5 shows digit k+1.
  - HEX4 is blank.
  - HEX3..HEX0 show acc as 4 decimal digits, leading zeros shown.
- Displays in RESULT:
  - HEX5..HEX3 are blank.
  - HEX2..HEX0 show "POS" if positive, "nEG" if negative.
- Glyph codes, bits [0:6]:
  - Digits: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Letters and blank: blank=1111111, P=0011000, O=0000001, S=0100100, n=1101010, E=0110000, G=0100001.
- LEDR in ENTRY(k): LEDR[k]=1, all other bits 0.
- LEDR in RESULT: LEDR[0:7]=0, LEDR[8]=1, LEDR[9]=verdict.

## Timing
- SW and KEY[1] are asynchronous.
  - Each passes through a synchronizer register s1, then a history register s2.
  - edge = s1 & ~s2.
  - Registered state acts on that edge one clock later, so an effect is visible after the 2nd rising clock following the input rise.
- During reset, s1 and s2 load the live inputs. An input held high through reset release therefore produces no edge.
- Held inputs act once per rising edge. Pulses shorter than one clock period are not guaranteed to be seen.
- Reset values:
  - HEX5 shows "1", HEX4 is blank, HEX3..HEX0 show "0000".
  - LEDR = 1000000000.
- Reset mid-entry or in RESULT discards everything within 1 clock.
- Outputs are decoded combinationally from registered state. No output glitch filtering is required.

## Test plan
- Reset → HEX5 shows "1", HEX4 is blank, HEX3..HEX0 = "0000", LEDR[0]=1 only.
- Enter SW1,SW4,SW8 in ENTRY(1) → HEX3..HEX0 = "0148"; next → HEX5="3", LEDR[2]=1, display "0000".
- Full entry of 6 / 148 / 72 / 35 / 0 / 37 / 627 / 50 with next after each field → RESULT, HEX2..HEX0 = "POS", LEDR[8]=1, LEDR[9]=1.
- Full entry of 1 / 85 / 66 / 29 / 0 / 26 / 351 / 31 → "nEG", LEDR[9]=0; then 5 more digit edges and a next → no change.
- Enter digits 1,2,3,4,5 → display "1234" (the 5th digit is ignored). SW3 and SW7 rising in the same cycle → digit 3 only.
- Reset pulse in ENTRY(4) with acc=12 → ENTRY(0), "0000", fields cleared. A later full negative sequence must yield "nEG".
